// File: rtl/rca_wb_sequencer.sv
// rca_wb_sequencer: buffers RCA multi-result writebacks and serialises them onto one register-file write port
module rca_wb_sequencer #(
   parameter int NUM_WRITE_PORTS = 5,
   parameter int XLEN = 32,
   parameter int ID_W = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wb_done,
   input  logic [ID_W-1:0]              wb_id,
   input  logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd,
   input  logic [NUM_WRITE_PORTS*5-1:0] wb_rd_addr,
   output logic                         wb_ready,
   input  logic                         rf_grant,
   output logic                         rf_we,
   output logic [4:0]                   rf_waddr,
   output logic [XLEN-1:0]              rf_wdata,
   output logic [ID_W-1:0]              rf_id,
   output logic                         retire_valid,
   output logic [ID_W-1:0]              retire_id,
   output logic                         overflow_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(NUM_WRITE_PORTS + 1);
   typedef enum logic {IDLE, WRITE} state_t;
   state_t state, state_nxt;
   logic [ID_W-1:0] mem_id [FIFO_DEPTH];
   logic [NUM_WRITE_PORTS*XLEN-1:0] mem_rd [FIFO_DEPTH];
   logic [NUM_WRITE_PORTS*5-1:0] mem_addr [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [PW-1:0] p, p_nxt, q;
   logic [ID_W-1:0] head_id;
   logic [NUM_WRITE_PORTS*XLEN-1:0] head_rd;
   logic [NUM_WRITE_PORTS*5-1:0] head_addr;
   logic found, more, push, pop, full, w;
   assign full = count == CW'(FIFO_DEPTH);
   assign wb_ready = !full;
   assign push = wb_done && !full;
   assign head_id = mem_id[rd_ptr];
   assign head_rd = mem_rd[rd_ptr];
   assign head_addr = mem_addr[rd_ptr];
   // find the first nonzero destination at or after p, and whether another follows it
   always_comb begin
      found = 1'b0;
      more = 1'b0;
      q = '0;
      for (int i = 0; i < NUM_WRITE_PORTS; i++)
         if (i >= int'(p) && head_addr[i*5 +: 5] != 5'd0) begin
            if (found) more = 1'b1;
            else begin
               found = 1'b1;
               q = PW'(i);
            end
         end
   end
   // write-port outputs, pop/retire decision and next state; an entry with no real destination retires unconditionally
   always_comb begin
      w = state == WRITE && found;
      pop = state == WRITE && (!found || (rf_grant && !more));
      rf_we = w;
      rf_waddr = w ? head_addr[int'(q)*5 +: 5] : 5'd0;
      rf_wdata = w ? head_rd[int'(q)*XLEN +: XLEN] : '0;
      rf_id = w ? head_id : '0;
      retire_valid = pop;
      retire_id = pop ? head_id : '0;
      count_nxt = count + CW'(push) - CW'(pop);
      state_nxt = state == IDLE ? (count != '0 ? WRITE : IDLE) : pop ? (count_nxt != '0 ? WRITE : IDLE) : WRITE;
      p_nxt = (state == IDLE || pop) ? '0 : rf_grant ? q + PW'(1) : p;
   end
   // control state, FIFO pointers and sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         p <= '0;
         count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         overflow_err <= 1'b0;
      end else begin
         state <= state_nxt;
         p <= p_nxt;
         count <= count_nxt;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         if (wb_done && full) overflow_err <= 1'b1;
      end
   end
   // writeback storage at the FIFO tail
   always_ff @(posedge clk) begin
      if (push) begin
         mem_id[wr_ptr] <= wb_id;
         mem_rd[wr_ptr] <= wb_rd;
         mem_addr[wr_ptr] <= wb_rd_addr;
      end
   end
endmodule

// File: tb/tb_rca_wb_sequencer.sv
// tb_rca_wb_sequencer: directed checks of writeback buffering, serialisation, stalls, overflow and reset
module tb_rca_wb_sequencer;
   logic clk = 1'b0, rst = 1'b1;
   logic wb_done = 1'b0;
   logic [2:0] wb_id = '0;
   logic [159:0] wb_rd = '0;
   logic [24:0] wb_rd_addr = '0;
   logic wb_ready, rf_grant = 1'b1, rf_we, retire_valid, overflow_err;
   logic [4:0] rf_waddr;
   logic [31:0] rf_wdata;
   logic [2:0] rf_id, retire_id;
   int n_chk = 0, n_pass = 0;
   rca_wb_sequencer dut (
      .clk(clk), .rst(rst), .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd),
      .wb_rd_addr(wb_rd_addr), .wb_ready(wb_ready), .rf_grant(rf_grant), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_id(rf_id), .retire_valid(retire_valid),
      .retire_id(retire_id), .overflow_err(overflow_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask
   task automatic tick;
      @(negedge clk);
      wb_done = 1'b0;
   endtask
   task automatic push_in(input logic [2:0] id, input logic [24:0] a, input logic [31:0] base);
      wb_done = 1'b1;
      wb_id = id;
      wb_rd_addr = a;
      for (int i = 0; i < 5; i++) wb_rd[i*32 +: 32] = base + i;
   endtask
   task automatic exp_w(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic [2:0] wid, input logic rv, input logic [2:0] rid);
      #1;
      chk({tag, ".we"}, rf_we, we);
      chk({tag, ".waddr"}, rf_waddr, a);
      chk({tag, ".wdata"}, rf_wdata, d);
      chk({tag, ".rf_id"}, rf_id, wid);
      chk({tag, ".retire"}, retire_valid, rv);
      if (rv) chk({tag, ".retire_id"}, retire_id, rid);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.ready", wb_ready, 1);
      chk("rst.ovf", overflow_err, 0);
      exp_w("rst", 0, 0, 0, 0, 0, 0);
      // single full writeback, ports 1..5
      tick; push_in(3, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 32'hA0);
      tick; exp_w("t1.c1", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick; exp_w($sformatf("t1.w%0d", i), 1, 5'(i + 1), 32'hA0 + i, 3, i == 4, 3);
      end
      tick; exp_w("t1.end", 0, 0, 0, 0, 0, 0);
      // x0 skipping
      tick; push_in(5, {5'd9, 5'd0, 5'd0, 5'd7, 5'd0}, 32'hB0);
      tick; exp_w("t2.c1", 0, 0, 0, 0, 0, 0);
      tick; exp_w("t2.x7", 1, 7, 32'hB1, 5, 0, 0);
      tick; exp_w("t2.x9", 1, 9, 32'hB4, 5, 1, 5);
      tick; exp_w("t2.end", 0, 0, 0, 0, 0, 0);
      tick; push_in(6, 25'd0, 32'hBB);
      tick; exp_w("t2z.c1", 0, 0, 0, 0, 0, 0);
      tick; exp_w("t2z.c2", 0, 0, 0, 0, 1, 6);
      tick; exp_w("t2z.c3", 0, 0, 0, 0, 0, 0);
      // grant stall on the second write
      tick; push_in(2, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 32'hC0);
      tick;
      tick; exp_w("t3.x1", 1, 1, 32'hC0, 2, 0, 0);
      tick; rf_grant = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick;
         exp_w($sformatf("t3.hold%0d", i), 1, 2, 32'hC1, 2, 0, 0);
      end
      tick; rf_grant = 1'b1; exp_w("t3.x2", 1, 2, 32'hC1, 2, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick; exp_w($sformatf("t3.x%0d", i + 3), 1, 5'(i + 3), 32'hC2 + i, 2, i == 2, 2);
      end
      tick; exp_w("t3.end", 0, 0, 0, 0, 0, 0);
      // back-to-back fill, overflow drop, then drain without a bubble
      rf_grant = 1'b0;
      tick; push_in(1, {5'd0, 5'd0, 5'd0, 5'd11, 5'd10}, 32'hD0);
      tick; push_in(2, {5'd0, 5'd0, 5'd0, 5'd0, 5'd12}, 32'hE0);
      #1; chk("t4.ready1", wb_ready, 1);
      tick; push_in(4, {5'd0, 5'd0, 5'd0, 5'd0, 5'd13}, 32'hF0);
      #1; chk("t4.full", wb_ready, 0);
      exp_w("t4.wait", 1, 10, 32'hD0, 1, 0, 0);
      tick; rf_grant = 1'b1;
      #1; chk("t4.ovf", overflow_err, 1);
      chk("t4.ready2", wb_ready, 0);
      exp_w("t4.x10", 1, 10, 32'hD0, 1, 0, 0);
      tick; exp_w("t4.x11", 1, 11, 32'hD1, 1, 1, 1);
      tick; exp_w("t4.x12", 1, 12, 32'hE0, 2, 1, 2);
      tick; exp_w("t4.end", 0, 0, 0, 0, 0, 0);
      chk("t4.ovf_hold", overflow_err, 1);
      // simultaneous push and pop at count 1
      tick; push_in(3, {5'd0, 5'd0, 5'd0, 5'd0, 5'd1}, 32'h10);
      tick;
      tick; push_in(7, {5'd0, 5'd0, 5'd0, 5'd0, 5'd2}, 32'h20);
      exp_w("t5.x1", 1, 1, 32'h10, 3, 1, 3);
      tick; chk("t5.ready", wb_ready, 1);
      exp_w("t5.x2", 1, 2, 32'h20, 7, 1, 7);
      tick; exp_w("t5.end", 0, 0, 0, 0, 0, 0);
      // async reset mid-drain
      tick; push_in(5, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 32'h30);
      tick;
      tick; exp_w("t6.x1", 1, 1, 32'h30, 5, 0, 0);
      tick; exp_w("t6.x2", 1, 2, 32'h31, 5, 0, 0);
      tick; exp_w("t6.x3", 1, 3, 32'h32, 5, 0, 0);
      #1; rst = 1'b1;
      #1; exp_w("t6.rst", 0, 0, 0, 0, 0, 0);
      chk("t6.ready", wb_ready, 1);
      chk("t6.ovf", overflow_err, 0);
      tick; rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick; exp_w($sformatf("t6.after%0d", i), 0, 0, 0, 0, 0, 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rca_wb_sequencer.md
Name: rca_wb_sequencer

Overview:
- Consumer end of the RCA writeback interface.
- Accepts one multi-result writeback per RCA instruction: a done pulse carrying the instruction id, NUM_WRITE_PORTS result words and NUM_WRITE_PORTS destination register addresses.
- Buffers each writeback, then serialises it onto the single shared register-file write port, one result per granted cycle.
- Signals instruction retirement after the last result is written. Sits between the RCA unit and the Taiga register file / writeback arbiter.

Parameters:
NUM_WRITE_PORTS, 5, results per RCA writeback
XLEN, 32, result word width
ID_W, 3, instruction id width
FIFO_DEPTH, 2, buffered writebacks (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_done  in  1  one-cycle pulse, writeback valid
wb_id  in  ID_W  instruction id
wb_rd  in  NUM_WRITE_PORTS*XLEN  results, port i at bits [i*XLEN +: XLEN]
wb_rd_addr  in  NUM_WRITE_PORTS*5  destination regs, port i at [i*5 +: 5]
wb_ready  out  1  FIFO not full; feeds RCA issue.ready
rf_grant  in  1  register-file port granted this cycle
rf_we  out  1  write request
rf_waddr  out  5  write address
rf_wdata  out  XLEN  write data
rf_id  out  ID_W  id of instruction being written
retire_valid  out  1  one-cycle pulse, instruction complete
retire_id  out  ID_W  id retired
overflow_err  out  1  sticky: writeback dropped

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied, state IDLE, port index p=0.
  - overflow_err=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_id=0, retire_valid=0, retire_id=0, wb_ready=1.
  - Reset mid-drain discards all buffered and partially written entries; no retire is issued for them.
- Push:
  - On a clk edge with wb_done=1 and count<FIFO_DEPTH, {id, rd vector, addr vector} is written at the tail.
  - wb_ready = (count<FIFO_DEPTH), computed from registered count; a pop in the same cycle does not free space.
  - wb_done=1 while full: entry dropped, overflow_err set to 1 and held until reset.
- FSM, two states:
  - IDLE: rf_we=0, retire_valid=0, rf_* outputs=0. Transition to WRITE on the next edge when count!=0, with p=0.
  - WRITE: operates on the head entry.
- Port selection in WRITE:
  - Let q = lowest port index >= p with addr[q]!=0.
  - Ports with addr==0 (x0) are skipped with no cycle cost.
- Writes in WRITE when q exists:
  - rf_we=1, rf_waddr=addr[q], rf_wdata=rd[q], rf_id=head id.
  - Outputs hold stable until rf_grant=1. p advances to q+1 only on an edge with rf_grant=1.
- Retire:
  - retire_valid=1 and retire_id=head id in the cycle where the granted write is the last nonzero-addr port.
  - If the head has no nonzero addr: one cycle in WRITE with rf_we=0 and retire_valid=1, independent of rf_grant.
  - Head is popped on that edge. Next state is WRITE with p=0 if post-pop count!=0, else IDLE. No bubble between entries.
- Duplicate destination addresses are written in port order (higher port wins in the register file).
- Latency, uncontended: wb_done high in cycle 0 -> entry visible cycle 1 -> first rf_we in cycle 2 -> retire in cycle 1+k, where k = number of nonzero addresses (minimum 2).
- FIFO pointers wrap modulo FIFO_DEPTH. count is ($clog2(FIFO_DEPTH)+1) bits.
- Simultaneous push and pop in one cycle: both take effect, count unchanged.

Test Plan:
- Reset then single push: id=3, addrs {1,2,3,4,5}, rd {A0..A4}, rf_grant=1 -> rf_we cycles 2..6 write x1=A0 .. x5=A4; retire_valid with retire_id=3 in cycle 6.
- x0 skipping: addrs {0,7,0,0,9} -> exactly two writes, x7 then x9; retire with the second. All addrs 0 -> no rf_we, retire_valid for one cycle.
- Grant stall: rf_grant=0 for 3 cycles on the second write -> rf_waddr/rf_wdata held constant; retire delayed by exactly 3 cycles.
- Back-to-back and full: push id=1 and id=2 in consecutive cycles with rf_grant=0 -> wb_ready=0 after the second push. Third push id=4 -> dropped, overflow_err=1. Release grant -> id 1 retires, then id 2 with no idle cycle; id 4 never appears.
- Simultaneous push/pop at count=1 -> count stays 1, order preserved.
- Async reset asserted mid-drain (after 2 of 5 writes) -> all outputs to reset values immediately; no retire for that id; wb_ready=1 and overflow_err=0.
